sha256_round_ctrl: RTL

Control FSM for one SHA-256 compression. It accepts a block-start request and sequences working-variable load, the 64 rounds and the final hash update. It drives the round counter through its clear and count-enable inputs and reads the count back to detect the last round and address the K/W datapath. It sits between the message front end and the compression datapath; the shared round counter is the other end of its counter interface.

---
 rtl/sha256_round_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/sha256_round_ctrl.sv
// Control FSM for one SHA-256 compression: working-variable load, ROUNDS rounds
// and the final H update. It steers an external round counter through clear/enable.
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       start_i,
  input  logic       first_blk_i,
  input  logic       abort_i,
  input  logic [7:0] i_i,
  output logic       clr_i_o,
  output logic       cnt_i_en_o,
  output logic       ld_iv_o,
  output logic       ld_abc_o,
  output logic       rnd_en_o,
  output logic       w_sel_msg_o,
  output logic [5:0] k_addr_o,
  output logic       upd_h_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    UPDATE,
    DONE
  } state_t;

  localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

  state_t state, state_nxt;
  logic   first_blk_q, first_blk_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      first_blk_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      first_blk_q <= first_blk_d;
    end
  end

  always_comb begin
    state_nxt   = state;
    first_blk_d = first_blk_q;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt   = INIT;
          first_blk_d = first_blk_i;
        end
      end
      INIT:   state_nxt = ROUND;
      // >= rather than == so an overshooting counter still terminates the block
      ROUND:  if (i_i >= LAST_RND) state_nxt = UPDATE;
      UPDATE: state_nxt = DONE;
      DONE: begin
        if (start_i) begin
          state_nxt   = INIT;
          first_blk_d = first_blk_i;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_i) begin
      state_nxt   = IDLE;
      first_blk_d = first_blk_q;
    end
  end

  always_comb begin
    clr_i_o     = 1'b0;
    cnt_i_en_o  = 1'b0;
    ld_iv_o     = 1'b0;
    ld_abc_o    = 1'b0;
    rnd_en_o    = 1'b0;
    w_sel_msg_o = 1'b0;
    k_addr_o    = '0;
    upd_h_o     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state)
      IDLE: clr_i_o = 1'b1;
      INIT: begin
        clr_i_o  = 1'b1;
        ld_abc_o = 1'b1;
        ld_iv_o  = first_blk_q;
        busy_o   = 1'b1;
      end
      ROUND: begin
        rnd_en_o    = 1'b1;
        cnt_i_en_o  = 1'b1;
        busy_o      = 1'b1;
        k_addr_o    = i_i[5:0];
        w_sel_msg_o = (i_i < 8'd16);
      end
      UPDATE: begin
        upd_h_o = 1'b1;
        busy_o  = 1'b1;
      end
      DONE: begin
        done_o  = 1'b1;
        clr_i_o = 1'b1;
        busy_o  = 1'b1;
      end
      default: clr_i_o = 1'b1;
    endcase
  end

endmodule
